// File: rtl/snoop_responder.sv
// snoop_responder: looks up the MESI state for a snooped bus op, answers NOHIT/HIT/HITM, writes back dirty lines and issues one state update.
// Optional hit statistics counters are enabled by defining SNOOP_RESP_STATS_EN.
module snoop_responder #(
    parameter int ADDR_W     = 32,
    parameter int LOOKUP_LAT = 2,
    parameter int WB_BEATS   = 4,
    localparam int BW        = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snp_valid,
    output logic              snp_ready,
    input  logic [2:0]        snp_op,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              lu_req,
    output logic [ADDR_W-1:0] lu_addr,
    input  logic [1:0]        lu_state,
    output logic              res_valid,
    output logic [1:0]        res_code,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [BW-1:0]     wb_beat,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              upd_valid,
    output logic [1:0]        upd_state,
    output logic [ADDR_W-1:0] upd_addr
`ifdef SNOOP_RESP_STATS_EN
    ,
    output logic [15:0]       cnt_nohit,
    output logic [15:0]       cnt_hit,
    output logic [15:0]       cnt_hitm
`endif
);
    localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd3;
    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, WB, UPD} state_t;
    state_t            state_q;
    logic              ready_q, lu_req_q, res_valid_q, wb_valid_q, upd_valid_q;
    logic [1:0]        res_code_q, upd_state_q, mesi_q;
    logic [2:0]        op_q, cnt_q;
    logic [BW-1:0]     beat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        upd_state_d;
    logic              op_ok, wb_go, last_beat;
    assign op_ok       = (snp_op != 3'd0) && (snp_op <= OP_RWIM);
    assign wb_go       = (mesi_q == ST_M) && (op_q == OP_READ || op_q == OP_RWIM);
    assign last_beat   = beat_q == BW'(WB_BEATS - 1);
    assign upd_state_d = (op_q == OP_RWIM) ? ST_I :
                         (op_q == OP_READ && mesi_q[1]) ? ST_S :
                         (op_q == OP_INV && mesi_q == ST_S) ? ST_I : mesi_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            lu_req_q    <= 1'b0;
            res_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            upd_valid_q <= 1'b0;
            res_code_q  <= 2'd0;
            upd_state_q <= 2'd0;
            mesi_q      <= 2'd0;
            op_q        <= 3'd0;
            cnt_q       <= 3'd0;
            beat_q      <= '0;
            addr_q      <= '0;
        end else begin
            lu_req_q    <= 1'b0;
            res_valid_q <= 1'b0;
            upd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (snp_valid && ready_q) begin
                        ready_q  <= 1'b0;
                        op_q     <= snp_op;
                        addr_q   <= snp_addr;
                        cnt_q    <= 3'd0;
                        lu_req_q <= op_ok;
                        // Unknown ops pass through UPD with no pulse to get the two-cycle turnaround
                        state_q  <= op_ok ? LOOKUP : UPD;
                    end
                end
                LOOKUP: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(LOOKUP_LAT)) begin
                        mesi_q      <= lu_state;
                        res_valid_q <= 1'b1;
                        res_code_q  <= (lu_state == ST_I) ? 2'd0 : (lu_state == ST_M) ? 2'd2 : 2'd1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    wb_valid_q  <= wb_go;
                    beat_q      <= '0;
                    upd_valid_q <= !wb_go && (upd_state_d != mesi_q);
                    upd_state_q <= upd_state_d;
                    state_q     <= wb_go ? WB : UPD;
                end
                WB: begin
                    if (wb_ready) begin
                        beat_q      <= last_beat ? beat_q : beat_q + BW'(1);
                        wb_valid_q  <= !last_beat;
                        upd_valid_q <= last_beat && (upd_state_d != mesi_q);
                        upd_state_q <= upd_state_d;
                        state_q     <= last_beat ? UPD : WB;
                    end
                end
                UPD: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign snp_ready = ready_q;
    assign lu_req    = lu_req_q;
    assign lu_addr   = addr_q;
    assign res_valid = res_valid_q;
    assign res_code  = res_code_q;
    assign wb_valid  = wb_valid_q;
    assign wb_beat   = beat_q;
    assign wb_addr   = addr_q;
    assign upd_valid = upd_valid_q;
    assign upd_state = upd_state_q;
    assign upd_addr  = addr_q;
`ifdef SNOOP_RESP_STATS_EN
    logic [15:0] nohit_q, hit_q, hitm_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            nohit_q <= 16'd0;
            hit_q   <= 16'd0;
            hitm_q  <= 16'd0;
        end else if (res_valid_q) begin
            nohit_q <= nohit_q + 16'((res_code_q == 2'd0) && (nohit_q != 16'hFFFF));
            hit_q   <= hit_q + 16'((res_code_q == 2'd1) && (hit_q != 16'hFFFF));
            hitm_q  <= hitm_q + 16'((res_code_q == 2'd2) && (hitm_q != 16'hFFFF));
        end
    end
    assign cnt_nohit = nohit_q;
    assign cnt_hit   = hit_q;
    assign cnt_hitm  = hitm_q;
`endif
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: scoreboard bench for snoop_responder with default parameters.
module tb_snoop_responder;
    localparam int AW = 32, LAT = 2, NB = 4, BW = 2;
    logic          clk = 1'b0, rst = 1'b1;
    logic          snp_valid = 1'b0, snp_ready;
    logic [2:0]    snp_op = 3'd0;
    logic [AW-1:0] snp_addr = '0;
    logic          lu_req;
    logic [AW-1:0] lu_addr;
    logic [1:0]    lu_state = 2'd0;
    logic          res_valid;
    logic [1:0]    res_code;
    logic          wb_valid, wb_ready = 1'b0;
    logic [BW-1:0] wb_beat;
    logic [AW-1:0] wb_addr;
    logic          upd_valid;
    logic [1:0]    upd_state;
    logic [AW-1:0] upd_addr;

    snoop_responder #(.ADDR_W(AW), .LOOKUP_LAT(LAT), .WB_BEATS(NB)) dut (
        .clk(clk), .rst(rst), .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op),
        .snp_addr(snp_addr), .lu_req(lu_req), .lu_addr(lu_addr), .lu_state(lu_state),
        .res_valid(res_valid), .res_code(res_code), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_beat(wb_beat), .wb_addr(wb_addr), .upd_valid(upd_valid), .upd_state(upd_state),
        .upd_addr(upd_addr)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0=result, 1=writeback beat, 2=update, 3=lookup; cyc<0 means timing not checked
    typedef struct {int kind; logic [31:0] val; int cyc;} ev_t;
    ev_t q[$];
    int n_chk = 0, n_fail = 0;
    logic [1:0] cur_st = 2'd0;
    int lu_age = -1;
    bit wb_pat[$];
    bit wb_dflt = 1'b1;
    bit stalled = 1'b0;
    logic [BW-1:0] st_beat = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_next(input logic [2:0] op, input logic [1:0] s);
        case (op)
            3'd1:    return (s >= 2'd2) ? 2'd1 : s;
            3'd3:    return (s == 2'd1) ? 2'd0 : s;
            3'd4:    return 2'd0;
            default: return s;
        endcase
    endfunction

    task automatic observe(input int kind, input logic [31:0] val);
        ev_t e;
        if (q.size() == 0) begin
            check("unexpected_event_kind", kind, 32'hFF);
            return;
        end
        e = q.pop_front();
        check("event_kind", kind, e.kind);
        check($sformatf("event_val_k%0d", kind), val, e.val);
        if (e.cyc >= 0) check($sformatf("event_cycle_k%0d", kind), cyc, e.cyc);
    endtask

    // Lookup responder, writeback sink and output monitor, all on the falling edge
    always @(negedge clk) begin
        if (lu_req) lu_age = 0;
        else if (lu_age >= 0) lu_age++;
        lu_state = (lu_age == LAT) ? cur_st : ~cur_st;
        wb_ready = wb_valid ? (wb_pat.size() != 0 ? wb_pat.pop_front() : wb_dflt) : 1'b0;
        if (rst) stalled = 1'b0;
        else begin
            if (stalled) begin
                check("wb_hold_valid", wb_valid, 1);
                check("wb_hold_beat", wb_beat, st_beat);
            end
            stalled = wb_valid && !wb_ready;
            st_beat = wb_beat;
            if (lu_req || res_valid || upd_valid)
                check("pulse_overlap", int'(lu_req) + int'(res_valid) + int'(upd_valid), 1);
            if (lu_req) observe(3, lu_addr);
            if (res_valid) observe(0, {30'd0, res_code});
            if (wb_valid && wb_ready) observe(1, {wb_addr[29:0], wb_beat});
            if (upd_valid) observe(2, {upd_addr[29:0], upd_state});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic snoop(input logic [2:0] op, input logic [31:0] a, input logic [1:0] st, output int acc);
        int n = 0;
        logic [1:0] rc, ns;
        bit wb;
        cur_st = st;
        snp_valid = 1'b1;
        snp_op = op;
        snp_addr = a;
        while (!snp_ready && n < 100) begin
            step();
            n++;
        end
        check("accept_in_time", n < 100, 1);
        acc = cyc;
        if (op >= 3'd1 && op <= 3'd4) begin
            rc = (st == 2'd0) ? 2'd0 : (st == 2'd3) ? 2'd2 : 2'd1;
            wb = (st == 2'd3) && (op == 3'd1 || op == 3'd4);
            ns = model_next(op, st);
            q.push_back('{3, a, acc + 1});
            q.push_back('{0, {30'd0, rc}, acc + LAT + 2});
            if (wb) for (int b = 0; b < NB; b++) q.push_back('{1, {a[29:0], 2'(b)}, -1});
            if (ns != st) q.push_back('{2, {a[29:0], ns}, wb ? -1 : acc + LAT + 3});
        end
        step();
        snp_valid = 1'b0;
    endtask

    task automatic drain(output int rdy);
        int n = 0;
        while ((q.size() != 0 || !snp_ready) && n < 200) begin
            step();
            n++;
        end
        check("drain_in_time", n < 200, 1);
        rdy = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int acc, acc2, rdy, n;
        repeat (3) step();
        check("rst_ready", snp_ready, 0);
        check("rst_lu_req", lu_req, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_addr", upd_addr, 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", snp_ready, 1);

        snoop(3'd1, 32'h0000_1040, 2'd2, acc);
        drain(rdy);
        check("read_e_ready_back", rdy, acc + LAT + 4);

        wb_pat = '{1, 0, 1, 1, 0, 1};
        snoop(3'd4, 32'h0000_2080, 2'd3, acc);
        drain(rdy);
        check("rwim_m_ready_back", rdy, acc + LAT + 10);

        snoop(3'd3, 32'h0000_30C0, 2'd1, acc);
        drain(rdy);
        snoop(3'd3, 32'h0000_3100, 2'd0, acc);
        drain(rdy);
        check("inv_i_ready_back", rdy, acc + LAT + 4);

        snoop(3'd2, 32'h0000_4000, 2'd3, acc);
        snoop(3'd2, 32'h0000_4040, 2'd3, acc2);
        check("back_to_back_gap", acc2 - acc, LAT + 4);
        drain(rdy);

        snoop(3'd7, 32'h0000_5000, 2'd3, acc);
        check("nop_busy", snp_ready, 0);
        step();
        check("nop_ready_back", snp_ready, 1);
        check("nop_cycle", cyc, acc + 2);

        wb_dflt = 1'b0;
        wb_pat = '{1};
        snoop(3'd4, 32'h0000_6000, 2'd3, acc);
        n = 0;
        while (!(wb_valid && wb_beat == 2'd1) && n < 50) begin
            step();
            n++;
        end
        check("beat1_reached", n < 50, 1);
        rst = 1'b1;
        step();
        check("rst_mid_wb_valid", wb_valid, 0);
        check("rst_mid_upd_valid", upd_valid, 0);
        rst = 1'b0;
        step();
        check("rst_mid_ready", snp_ready, 1);
        check("rst_mid_discarded", q.size(), NB);
        q.delete();
        wb_dflt = 1'b1;
        repeat (6) step();

        snoop(3'd1, 32'h0000_7000, 2'd3, acc);
        drain(rdy);
        check("read_m_ready_back", rdy, acc + LAT + 4 + NB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
